peripheral_bin2bcd: RTL and testbench
=====================================

// Module: peripheral_bin2bcd
// PURPOSE
//  J1 memory-mapped peripheral that converts a WIDTH-bit unsigned binary value to packed BCD.
//  It is the reverse-direction companion of the BCD-to-binary peripheral and uses the same bus handshake and register map style.
//  Conversion is sequential shift-add-3 (double dabble), one bit per clock, with FSM and datapath inside this module.
// PARAMETERS
//  WIDTH   16  binary operand width in bits
//  DIGITS  5   BCD output digits; the instantiator must ensure 10**DIGITS > 2**WIDTH-1 and 4*DIGITS <= 32
// PORTS
//  clk     in   1   single system clock; all state updates on posedge
//  reset   in   1   asynchronous, active-low reset (0 = reset)
//  d_in    in   32  write data from J1
//  cs      in   1   peripheral chip select
//  addr    in   5   register address (byte offsets below)
//  rd      in   1   read strobe, qualified by cs
//  wr      in   1   write strobe, qualified by cs
//  d_out   out  32  registered read data
// BEHAVIOUR
//  Register map (when cs=1):
//   0x04 W: A     <= d_in[WIDTH-1:0]; A is only an operand buffer; the running conversion uses a latched copy.
//   0x0C W: START; d_in[0]=1 requests a conversion; self-clearing, never stored.
//   0x10 R: d_out <= {zero-extend, result[4*DIGITS-1:0]}, packed BCD with the LS digit in bits [3:0].
//   0x14 R: d_out <= {30'b0, busy, done}.
//  Reads: d_out updates at the posedge where cs&&rd is true. It holds in every other case: unmapped address, cs=0, or write-only address.
//  Writes to an unmapped address are ignored.
//  Reset (reset=0, async): A=0, result=0, done=0, busy=0, d_out=0, FSM=IDLE, shift/bit counter=0.
//  FSM:
//   IDLE : if START is written, the operand latches A, the BCD shift reg=0, cnt=WIDTH, done<=0, busy<=1, next state=SHIFT.
//          An A write and a START at the same edge are impossible (different addresses).
//          START converts the A value registered at or before the previous edge.
//   SHIFT: each cycle, every BCD digit >=5 gets +3. Then {bcd,bin} shifts left by 1 and cnt decrements.
//          When cnt reaches 1 on this cycle, the next state is DONE.
//   DONE : result<=bcd reg, done<=1, busy<=0, next state=IDLE.
//  Latency: START written at edge N gives result valid and done=1 after edge N+WIDTH+1 (17 cycles for WIDTH=16).
//  done is sticky until the next accepted START; result holds its last value until overwritten in DONE.
//  START while busy=1 is ignored: no restart and no state change.
//  A writes while busy are accepted into A but do not affect the running conversion.
//  Digit arithmetic is 4 bits per digit. The add-3 check uses the pre-shift digit. No carry between digits except through the shift.
//  Reset asserted mid-conversion aborts immediately to reset values, with no partial result.
// CONFIGURATION
//  BIN2BCD_IRQ_EN defined:
//   - adds output port irq (1 bit, after d_out) and register 0x18 R/W IRQ_EN = d_in[0], reset 0.
//   - irq = done & IRQ_EN, registered; it drops when START clears done or when IRQ_EN is written 0.
//   - reads of 0x18 return {31'b0, IRQ_EN}.
//  BIN2BCD_IRQ_EN undefined: no irq port, 0x18 is unmapped (reads hold d_out, writes ignored).
// TESTING
//  1. Write A=0x04D2, START -> after 17 clk done=1; read 0x10 -> 0x00001234; read 0x14 -> 0x1.
//  2. A=0xFFFF, START -> result 0x00065535. A=0x0000 -> result 0x00000000 with done=1 at the same latency.
//  3. START with A=0x0009, then START again at cycle 5 plus a write A=0x0063 -> ignored; result 0x00000009 at cycle 17.
//     A fresh START then gives 0x00000099.
//  4. Drive reset=0 at cycle 8 of a conversion -> all regs 0 asynchronously; read 0x14 after release -> 0x0; no done pulse.
//  5. Read 0x14 during SHIFT -> 0x2 (busy); read unmapped 0x08 -> d_out unchanged from the previous read.
//  6. (BIN2BCD_IRQ_EN) IRQ_EN=1, START A=0x0064 -> irq=1 one clk after done. Next START -> irq=0. Result 0x00000100.

Source files
------------

// File: rtl/peripheral_bin2bcd.sv
// J1 memory-mapped binary-to-packed-BCD converter using sequential double dabble (one bit per clock).
// Optional interrupt output and IRQ_EN register are compiled in when BIN2BCD_IRQ_EN is defined.
module peripheral_bin2bcd #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_in,
   input  logic        cs,
   input  logic [4:0]  addr,
   input  logic        rd,
   input  logic        wr,
`ifdef BIN2BCD_IRQ_EN
   output logic [31:0] d_out,
   output logic        irq
`else
   output logic [31:0] d_out
`endif
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [4:0] ADDR_A      = 5'h04;
   localparam logic [4:0] ADDR_START  = 5'h0C;
   localparam logic [4:0] ADDR_RESULT = 5'h10;
   localparam logic [4:0] ADDR_STATUS = 5'h14;
`ifdef BIN2BCD_IRQ_EN
   localparam logic [4:0] ADDR_IRQ_EN = 5'h18;
`endif

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   bin_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [BCD_W-1:0]   bcd_adj_d;
   logic [BCD_W-1:0]   result_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               done_q;
   logic               busy_q;
   logic [31:0]        d_out_q;
   logic [31:0]        result_ext;
`ifdef BIN2BCD_IRQ_EN
   logic               irq_en_q;
   logic               irq_q;
`endif

   logic wr_en;
   logic rd_en;
   logic start_req;
   logic unused_d_in;

   assign wr_en       = cs & wr;
   assign rd_en       = cs & rd;
   assign start_req   = wr_en && (addr == ADDR_START) && d_in[0];
   assign unused_d_in = ^d_in;
   assign d_out       = d_out_q;
`ifdef BIN2BCD_IRQ_EN
   assign irq         = irq_q;
`endif

   // Add-3 correction looks at each digit before the shift; carries only travel via the shift.
   always_comb begin
      // NOTE: assign a full default first so no path through this block can infer a latch.
      bcd_adj_d  = bcd_q;
      result_ext = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      result_ext[BCD_W-1:0] = result_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         d_out_q  <= '0;
`ifdef BIN2BCD_IRQ_EN
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
         if (wr_en && (addr == ADDR_A)) begin
            a_q <= d_in[WIDTH-1:0];
         end
`ifdef BIN2BCD_IRQ_EN
         if (wr_en && (addr == ADDR_IRQ_EN)) begin
            irq_en_q <= d_in[0];
         end
         irq_q <= done_q & irq_en_q;
`endif

         // Reads of write-only or unmapped addresses leave d_out holding its last value.
         if (rd_en) begin
            case (addr)
               ADDR_RESULT: d_out_q <= result_ext;
               ADDR_STATUS: d_out_q <= {30'b0, busy_q, done_q};
`ifdef BIN2BCD_IRQ_EN
               ADDR_IRQ_EN: d_out_q <= {31'b0, irq_en_q};
`endif
               default:     ;
            endcase
         end

         case (state_q)
            IDLE: begin
               if (start_req) begin
                  bin_q   <= a_q;
                  bcd_q   <= '0;
                  cnt_q   <= CNT_W'(WIDTH);
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_q <= {bcd_adj_d[BCD_W-2:0], bin_q[WIDTH-1]};
               bin_q <= {bin_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               result_q <= bcd_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// Directed bench for peripheral_bin2bcd: bus writes/reads, conversion latency, and a queue of expected results.
module tb_peripheral_bin2bcd;

   logic        clk;
   logic        reset;
   logic [31:0] d_in;
   logic        cs;
   logic [4:0]  addr;
   logic        rd;
   logic        wr;
   logic [31:0] d_out;
`ifdef BIN2BCD_IRQ_EN
   logic        irq;
`endif

   int total;
   int bad;
   logic [31:0] exp_q[$];
   logic [31:0] rdata;

   peripheral_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
      .clk   (clk),
      .reset (reset),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
`ifdef BIN2BCD_IRQ_EN
      .irq   (irq),
`endif
      .d_out (d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference decimal-digit split, independent of the shift-add algorithm.
   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
      @(posedge clk);
      #1;
      cs = 1'b0; wr = 1'b0; d_in = '0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(posedge clk);
      #1;
      cs = 1'b0; rd = 1'b0;
      d = d_out;
   endtask

   // Start a conversion of value v and record its expected BCD result.
   task automatic start_conv(input int unsigned v);
      bus_write(5'h04, v);
      bus_write(5'h0C, 32'h1);
      exp_q.push_back(to_bcd(v));
   endtask

   // Poll STATUS every cycle; exp_k is the poll on which done must first appear.
   task automatic wait_done(input int exp_k, input string tag);
      int k;
      k = 0;
      cs = 1'b1; rd = 1'b1; addr = 5'h14;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) check({tag, "_busy"}, d_out, 32'h2);
      end while (d_out[0] !== 1'b1 && k < 60);
      cs = 1'b0; rd = 1'b0;
      check({tag, "_latency"}, k, exp_k);
      check({tag, "_status_done"}, d_out, 32'h1);
   endtask

   task automatic check_result(input string tag);
      logic [31:0] expv;
      bus_read(5'h10, rdata);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, rdata, 32'hxxxx_xxxx);
      end else begin
         expv = exp_q.pop_front();
         check(tag, rdata, expv);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
      #1;
      check("reset_dout", d_out, 32'h0);
      idle(2);
      reset = 1'b1;
      idle(1);
      bus_read(5'h14, rdata);
      check("reset_status", rdata, 32'h0);
      bus_read(5'h10, rdata);
      check("reset_result", rdata, 32'h0);

      // Basic conversion: 1234.
      start_conv(32'h04D2);
      wait_done(18, "c1234");
      check_result("res_1234");
      bus_read(5'h14, rdata);
      check("status_after_1234", rdata, 32'h1);

      // Boundary operands.
      start_conv(32'hFFFF);
      wait_done(18, "cffff");
      check_result("res_65535");
      start_conv(32'h0000);
      wait_done(18, "c0000");
      check_result("res_0");

      // START and A write while busy are ignored by the running conversion.
      start_conv(32'h0009);
      idle(3);
      bus_write(5'h04, 32'h0063);
      bus_write(5'h0C, 32'h1);
      wait_done(13, "c9_busy_start");
      check_result("res_9");
      bus_write(5'h0C, 32'h1);
      exp_q.push_back(to_bcd(99));
      wait_done(18, "c99");
      check_result("res_99");

      // Reads that must hold d_out: unmapped, write-only, cs low, 0x18 without the IRQ build.
      bus_read(5'h08, rdata);
      check("hold_unmapped", rdata, 32'h99);
      bus_read(5'h04, rdata);
      check("hold_wronly", rdata, 32'h99);
      addr = 5'h14; rd = 1'b1; cs = 1'b0;
      idle(1);
      rd = 1'b0;
      check("hold_cs_low", d_out, 32'h99);
`ifndef BIN2BCD_IRQ_EN
      bus_read(5'h18, rdata);
      check("hold_0x18", rdata, 32'h99);
`endif

      // START with d_in[0]=0 does nothing; done stays sticky.
      bus_write(5'h0C, 32'h2);
      bus_read(5'h14, rdata);
      check("start_bit0_clear", rdata, 32'h1);

      // Write to an unmapped address is ignored.
      bus_write(5'h04, 32'h002A);
      bus_write(5'h1C, 32'h0000_FFFF);
      bus_write(5'h0C, 32'h1);
      exp_q.push_back(to_bcd(42));
      wait_done(18, "c42");
      check_result("res_42");

      // Asynchronous reset mid-conversion.
      bus_write(5'h04, 32'd4660);
      bus_write(5'h0C, 32'h1);
      idle(7);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_dout", d_out, 32'h0);
      idle(2);
      reset = 1'b1;
      bus_read(5'h14, rdata);
      check("post_reset_status", rdata, 32'h0);
      bus_read(5'h10, rdata);
      check("post_reset_result", rdata, 32'h0);
      idle(25);
      bus_read(5'h14, rdata);
      check("no_done_after_abort", rdata, 32'h0);

`ifdef BIN2BCD_IRQ_EN
      bus_write(5'h18, 32'h1);
      bus_read(5'h18, rdata);
      check("irq_en_read", rdata, 32'h1);
      check("irq_idle_low", irq, 1'b0);
      start_conv(32'h0064);
      wait_done(18, "c100");
      check("irq_high", irq, 1'b1);
      check_result("res_100");
      bus_write(5'h0C, 32'h1);
      exp_q.push_back(to_bcd(100));
      idle(1);
      check("irq_drop_on_start", irq, 1'b0);
      wait_done(17, "c100b");
      check("irq_high_again", irq, 1'b1);
      check_result("res_100b");
      bus_write(5'h18, 32'h0);
      idle(1);
      check("irq_drop_on_disable", irq, 1'b0);
`endif

      check("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
